// File: rtl/tetromino_render_pkg.sv
// Shared encodings and offset table for the tetromino renderer.
// Offsets are in cell units relative to the piece reference cell, range -1..2.
package tetromino_render_pkg;

   localparam int DEFAULT_SIZE = 16;

   typedef enum logic [2:0] {
      PT_I   = 3'd0,
      PT_O   = 3'd1,
      PT_T   = 3'd2,
      PT_S   = 3'd3,
      PT_Z   = 3'd4,
      PT_J   = 3'd5,
      PT_L   = 3'd6,
      PT_RSV = 3'd7
   } piece_type_t;

   typedef enum logic [1:0] {
      OP_LOAD   = 2'd0,
      OP_MOVE   = 2'd1,
      OP_ROTATE = 2'd2,
      OP_CLEAR  = 2'd3
   } op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   typedef struct packed {
      logic signed [2:0] dx;
      logic signed [2:0] dy;
   } offset_t;

   localparam logic signed [2:0] M1 = -3'sd1;
   localparam logic signed [2:0] Z0 = 3'sd0;
   localparam logic signed [2:0] P1 = 3'sd1;
   localparam logic signed [2:0] P2 = 3'sd2;

   // Each rotation turns the previous one a quarter turn about the reference
   // cell, then shifts the I bar back into the -1..2 window.
   localparam offset_t SHAPE_TBL [0:6][0:3][0:3] = '{
      // I
      '{ '{'{M1,Z0}, '{Z0,Z0}, '{P1,Z0}, '{P2,Z0}},
         '{'{Z0,M1}, '{Z0,Z0}, '{Z0,P1}, '{Z0,P2}},
         '{'{P2,Z0}, '{P1,Z0}, '{Z0,Z0}, '{M1,Z0}},
         '{'{Z0,P2}, '{Z0,P1}, '{Z0,Z0}, '{Z0,M1}} },
      // O
      '{ '{'{Z0,Z0}, '{P1,Z0}, '{Z0,P1}, '{P1,P1}},
         '{'{Z0,Z0}, '{Z0,P1}, '{M1,Z0}, '{M1,P1}},
         '{'{Z0,Z0}, '{M1,Z0}, '{Z0,M1}, '{M1,M1}},
         '{'{Z0,Z0}, '{Z0,M1}, '{P1,Z0}, '{P1,M1}} },
      // T
      '{ '{'{M1,Z0}, '{Z0,Z0}, '{P1,Z0}, '{Z0,P1}},
         '{'{Z0,M1}, '{Z0,Z0}, '{Z0,P1}, '{M1,Z0}},
         '{'{P1,Z0}, '{Z0,Z0}, '{M1,Z0}, '{Z0,M1}},
         '{'{Z0,P1}, '{Z0,Z0}, '{Z0,M1}, '{P1,Z0}} },
      // S
      '{ '{'{Z0,Z0}, '{P1,Z0}, '{Z0,P1}, '{M1,P1}},
         '{'{Z0,Z0}, '{Z0,P1}, '{M1,Z0}, '{M1,M1}},
         '{'{Z0,Z0}, '{M1,Z0}, '{Z0,M1}, '{P1,M1}},
         '{'{Z0,Z0}, '{Z0,M1}, '{P1,Z0}, '{P1,P1}} },
      // Z
      '{ '{'{M1,Z0}, '{Z0,Z0}, '{Z0,P1}, '{P1,P1}},
         '{'{Z0,M1}, '{Z0,Z0}, '{M1,Z0}, '{M1,P1}},
         '{'{P1,Z0}, '{Z0,Z0}, '{Z0,M1}, '{M1,M1}},
         '{'{Z0,P1}, '{Z0,Z0}, '{P1,Z0}, '{P1,M1}} },
      // J
      '{ '{'{M1,Z0}, '{Z0,Z0}, '{P1,Z0}, '{P1,P1}},
         '{'{Z0,M1}, '{Z0,Z0}, '{Z0,P1}, '{M1,P1}},
         '{'{P1,Z0}, '{Z0,Z0}, '{M1,Z0}, '{M1,M1}},
         '{'{Z0,P1}, '{Z0,Z0}, '{Z0,M1}, '{P1,M1}} },
      // L
      '{ '{'{M1,Z0}, '{Z0,Z0}, '{P1,Z0}, '{M1,P1}},
         '{'{Z0,M1}, '{Z0,Z0}, '{Z0,P1}, '{M1,M1}},
         '{'{P1,Z0}, '{Z0,Z0}, '{M1,Z0}, '{P1,M1}},
         '{'{Z0,P1}, '{Z0,Z0}, '{Z0,M1}, '{P1,P1}} }
   };

endpackage

// File: rtl/tetromino_shape_rom.sv
// Combinational lookup of one cell offset for (type, rotation, cell index).
// The reserved type code reads as S so the output is always a defined shape.
module tetromino_shape_rom
   import tetromino_render_pkg::*;
(
   input  piece_type_t       piece_type,
   input  logic [1:0]        rot,
   input  logic [1:0]        idx,
   output logic signed [2:0] dx,
   output logic signed [2:0] dy
);

   piece_type_t ti;
   offset_t     ent;

   always_comb begin
      ti  = (piece_type == PT_RSV) ? PT_S : piece_type;
      ent = SHAPE_TBL[ti][rot][idx];
      dx  = ent.dx;
      dy  = ent.dy;
   end

endmodule

// File: rtl/tetromino_render.sv
// Tetromino piece state, 4-cycle shadow update with atomic commit, and pixel hit test.
// en_inner/en_edge are registered (1 cycle from addr); cmd_ready drops while an update is in flight.
module tetromino_render
   import tetromino_render_pkg::*;
#(
   parameter int SIZE = DEFAULT_SIZE,
   parameter int X_W  = 10,
   parameter int Y_W  = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [X_W-1:0] addr_x,
   input  logic [Y_W-1:0] addr_y,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [1:0]     cmd_op,
   input  logic [2:0]     cmd_type,
   input  logic [X_W-1:0] cmd_x,
   input  logic [Y_W-1:0] cmd_y,
   output logic           upd_done,
   output logic           en_inner,
   output logic           en_edge
);

   localparam int LOG2 = $clog2(SIZE);
   localparam int XE   = X_W + 2;
   localparam int YE   = Y_W + 2;

   state_t              state, state_nxt;
   op_t                 op;
   logic                rdy_q;
   logic                accept;
   piece_type_t         piece_type;
   logic [1:0]          rot;
   logic [X_W-1:0]      ref_x;
   logic [Y_W-1:0]      ref_y;
   logic                visible;
   logic                show;
   logic [1:0]          idx;
   logic signed [2:0]   dx, dy;
   logic [XE-1:0]       sum_x;
   logic [YE-1:0]       sum_y;
   logic signed [X_W:0] new_x;
   logic signed [Y_W:0] new_y;
   logic signed [X_W:0] sh_x [0:2];
   logic signed [Y_W:0] sh_y [0:2];
   logic signed [X_W:0] cx   [0:3];
   logic signed [Y_W:0] cy   [0:3];
   logic [XE-1:0]       lx;
   logic [YE-1:0]       ly;
   logic [3:0]          hit_in, hit_ed;

   assign op        = op_t'(cmd_op);
   assign cmd_ready = rdy_q && (state == ST_IDLE);
   assign accept    = cmd_valid && cmd_ready;

   tetromino_shape_rom u_rom (
      .piece_type (piece_type),
      .rot        (rot),
      .idx        (idx),
      .dx         (dx),
      .dy         (dy)
   );

   // Cells past the pixel range are parked at the most negative origin so
   // they can never alias back into the visible area.
   always_comb begin
      sum_x = {2'b00, ref_x} + ({{(XE-3){dx[2]}}, dx} << LOG2);
      sum_y = {2'b00, ref_y} + ({{(YE-3){dy[2]}}, dy} << LOG2);
      new_x = (sum_x[XE-1:XE-2] == 2'b01) ? {1'b1, {X_W{1'b0}}} : sum_x[X_W:0];
      new_y = (sum_y[YE-1:YE-2] == 2'b01) ? {1'b1, {Y_W{1'b0}}} : sum_y[Y_W:0];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept && (op != OP_CLEAR)) state_nxt = ST_BUSY;
         ST_BUSY: if (idx == 2'd3) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         piece_type <= PT_I;
         rot        <= 2'd0;
         ref_x      <= '0;
         ref_y      <= '0;
         visible    <= 1'b0;
      end else if (accept) begin
         case (op)
            OP_LOAD: begin
               piece_type <= (cmd_type == 3'd7) ? PT_S : piece_type_t'(cmd_type);
               rot        <= 2'd0;
               ref_x      <= cmd_x;
               ref_y      <= cmd_y;
               visible    <= 1'b1;
            end
            OP_MOVE: begin
               ref_x <= cmd_x;
               ref_y <= cmd_y;
            end
            OP_ROTATE: rot     <= rot + 2'd1;
            default:   visible <= 1'b0;
         endcase
      end
   end

   // The last cell goes straight from the adder into the committed set, so
   // all four origins change on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         rdy_q    <= 1'b0;
         idx      <= 2'd0;
         upd_done <= 1'b0;
         show     <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            sh_x[i] <= '0;
            sh_y[i] <= '0;
         end
         for (int i = 0; i < 4; i++) begin
            cx[i] <= '0;
            cy[i] <= '0;
         end
      end else begin
         state    <= state_nxt;
         rdy_q    <= 1'b1;
         upd_done <= 1'b0;
         if (state == ST_BUSY) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
               for (int i = 0; i < 3; i++) begin
                  cx[i] <= sh_x[i];
                  cy[i] <= sh_y[i];
               end
               cx[3]    <= new_x;
               cy[3]    <= new_y;
               show     <= visible;
               upd_done <= 1'b1;
            end else begin
               for (int i = 0; i < 3; i++) begin
                  if (idx == 2'(i)) begin
                     sh_x[i] <= new_x;
                     sh_y[i] <= new_y;
                  end
               end
            end
         end else begin
            idx <= 2'd0;
         end
         if (accept && (op == OP_CLEAR)) show <= 1'b0;
      end
   end

   // Local offsets are taken modulo the extended width; a pixel left of or
   // above a cell wraps to a large value and fails the < SIZE test.
   always_comb begin
      hit_in = '0;
      hit_ed = '0;
      lx     = '0;
      ly     = '0;
      for (int i = 0; i < 4; i++) begin
         lx = {2'b00, addr_x} - {cx[i][X_W], cx[i]};
         ly = {2'b00, addr_y} - {cy[i][Y_W], cy[i]};
         if ((lx < XE'(SIZE)) && (ly < YE'(SIZE))) begin
            if ((lx == '0) || (ly == '0) || (lx == XE'(SIZE - 1)) || (ly == YE'(SIZE - 1)))
               hit_ed[i] = 1'b1;
            else
               hit_in[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_inner <= 1'b0;
         en_edge  <= 1'b0;
      end else begin
         en_inner <= show && (|hit_in);
         en_edge  <= show && (|hit_ed);
      end
   end

endmodule

// File: tb/tb_tetromino_render.sv
// Randomized scoreboard bench for tetromino_render against a cell-geometry model.
module tb_tetromino_render;

   localparam int SZ = 16;
   // Base shapes (rotation 0) in cell units; other rotations are derived by quarter turns.
   localparam int BX [7][4] = '{'{-1,0,1,2}, '{0,1,0,1}, '{-1,0,1,0}, '{0,1,0,-1},
                                '{-1,0,0,1}, '{-1,0,1,1}, '{-1,0,1,-1}};
   localparam int BY [7][4] = '{'{0,0,0,0}, '{0,0,1,1}, '{0,0,0,1}, '{0,0,1,1},
                                '{0,0,1,1}, '{0,0,0,1}, '{0,0,0,1}};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] addr_x = '0, addr_y = '0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = '0;
   logic [2:0] cmd_type = '0;
   logic [9:0] cmd_x = '0, cmd_y = '0;
   logic       upd_done, en_inner, en_edge;

   tetromino_render dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .addr_x    (addr_x),
      .addr_y    (addr_y),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_type  (cmd_type),
      .cmd_x     (cmd_x),
      .cmd_y     (cmd_y),
      .upd_done  (upd_done),
      .en_inner  (en_inner),
      .en_edge   (en_edge)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit inn;
      bit edg;
      bit upd;
      bit rdy;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;

   // Model state: pending piece, committed piece, handshake bookkeeping.
   int m_rdy, m_busy, m_cnt, m_type, m_rot, m_x, m_y, m_vis;
   int c_type, c_rot, c_x, c_y, c_show;

   task automatic chk(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
      end
   endtask

   function automatic int clip(input int v);
      return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
   endfunction

   function automatic void model_hit(input int ty, input int r, input int px, input int py,
                                     input int ax, input int ay, output bit inn, output bit edg);
      int ox[4], oy[4];
      int t, mnx, mny, cxx, cyy;
      inn = 0;
      edg = 0;
      for (int i = 0; i < 4; i++) begin
         ox[i] = BX[ty][i];
         oy[i] = BY[ty][i];
      end
      for (int k = 0; k < r; k++)
         for (int i = 0; i < 4; i++) begin
            t     = ox[i];
            ox[i] = -oy[i];
            oy[i] = t;
         end
      mnx = 0;
      mny = 0;
      for (int i = 0; i < 4; i++) begin
         if (ox[i] < mnx) mnx = ox[i];
         if (oy[i] < mny) mny = oy[i];
      end
      for (int i = 0; i < 4; i++) begin
         if (mnx < -1) ox[i] += -1 - mnx;
         if (mny < -1) oy[i] += -1 - mny;
         cxx = px + ox[i] * SZ;
         cyy = py + oy[i] * SZ;
         if (ax >= cxx && ax <= cxx + SZ - 1 && ay >= cyy && ay <= cyy + SZ - 1) begin
            if (ax == cxx || ax == cxx + SZ - 1 || ay == cyy || ay == cyy + SZ - 1) edg = 1;
            else inn = 1;
         end
      end
   endfunction

   // One clock of stimulus: drive inputs, then advance the model across the coming edge.
   task automatic tick(input bit r, input bit v, input int op, input int ty, input int x,
                       input int y, input int ax, input int ay, output bit acc);
      exp_t e;
      bit   hi, he, rdy_now;
      @(negedge clk);
      #1;
      rst_n     = r;
      cmd_valid = v;
      cmd_op    = 2'(op);
      cmd_type  = 3'(ty);
      cmd_x     = 10'(x);
      cmd_y     = 10'(y);
      addr_x    = 10'(ax);
      addr_y    = 10'(ay);
      acc = 0;
      e.inn = 0; e.edg = 0; e.upd = 0; e.rdy = 0;
      if (!r) begin
         m_rdy = 0; m_busy = 0; m_cnt = 0; m_type = 0; m_rot = 0; m_x = 0; m_y = 0; m_vis = 0;
         c_type = 0; c_rot = 0; c_x = 0; c_y = 0; c_show = 0;
      end else begin
         hi = 0; he = 0;
         if (c_show != 0) model_hit(c_type, c_rot, c_x, c_y, ax, ay, hi, he);
         e.inn   = hi;
         e.edg   = he;
         rdy_now = (m_rdy != 0) && (m_busy == 0);
         acc     = rdy_now && v;
         if (m_busy != 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               c_type = m_type; c_rot = m_rot; c_x = m_x; c_y = m_y; c_show = m_vis;
               e.upd  = 1;
               m_busy = 0;
            end
         end
         if (acc) begin
            case (op)
               0: begin
                  m_type = (ty == 7) ? 3 : ty;
                  m_rot = 0; m_x = x; m_y = y; m_vis = 1; m_busy = 1; m_cnt = 4;
               end
               1: begin m_x = x; m_y = y; m_busy = 1; m_cnt = 4; end
               2: begin m_rot = (m_rot + 1) % 4; m_busy = 1; m_cnt = 4; end
               default: begin m_vis = 0; c_show = 0; end
            endcase
         end
         m_rdy = 1;
         e.rdy = (m_busy == 0);
      end
      q.push_back(e);
   endtask

   function automatic int near_x();
      return clip(m_x - 24 + int'($urandom_range(0, 88)));
   endfunction

   function automatic int near_y();
      return clip(m_y - 24 + int'($urandom_range(0, 88)));
   endfunction

   task automatic idle(input int ax, input int ay);
      bit acc;
      tick(1, 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), ax, ay, acc);
   endtask

   task automatic issue(input int op, input int ty, input int x, input int y);
      bit acc;
      int n;
      n = 0;
      do begin
         tick(1, 1, op, ty, x, y, near_x(), near_y(), acc);
         n++;
      end while (!acc && n < 20);
   endtask

   // Monitor: every sampled cycle is compared against the oldest expectation.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("en_inner", int'(en_inner), int'(e.inn));
            chk("en_edge", int'(en_edge), int'(e.edg));
            chk("upd_done", int'(upd_done), int'(e.upd));
            chk("cmd_ready", int'(cmd_ready), int'(e.rdy));
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bit acc;
      int sx[4], sy[4];
      int op, x, y;
      sx = '{64, 70, 48, 100};
      sy = '{64, 70, 80, 64};

      repeat (3) tick(0, 0, 0, 0, 0, 0, 0, 0, acc);
      repeat (2) idle(64, 64);

      // LOAD S at (64,64): settle, then probe edge / inner / edge / none.
      issue(0, 3, 64, 64);
      repeat (5) idle(near_x(), near_y());
      for (int i = 0; i < 4; i++) idle(sx[i], sy[i]);

      // Four back-to-back rotations return to the rotation-0 footprint.
      repeat (4) issue(2, 0, 0, 0);
      repeat (5) idle(near_x(), near_y());
      for (int i = 0; i < 4; i++) idle(sx[i], sy[i]);

      // MOVE to (8,8): one cell sits at x=-8 and must not alias to the right edge.
      issue(1, 0, 8, 8);
      repeat (5) idle(near_x(), near_y());
      for (int i = 0; i < 8; i++) idle(i, 30);
      for (int i = 1016; i < 1024; i++) idle(i, 30);
      idle(0, 24);
      idle(7, 39);

      // MOVE away while probing the old footprint through the busy window.
      issue(1, 0, 200, 150);
      repeat (3) idle(12, 12);
      repeat (3) idle(0, 30);
      repeat (3) idle(206, 156);

      // CLEAR hides the piece immediately and never stalls.
      issue(3, 0, 0, 0);
      repeat (4) idle(206, 156);
      repeat (2) idle(200, 150);

      // Reserved type code behaves as S.
      issue(0, 7, 600, 200);
      repeat (5) idle(near_x(), near_y());
      repeat (6) idle(near_x(), near_y());

      // Reset on the second busy cycle of a rotation aborts the update.
      issue(2, 0, 0, 0);
      idle(606, 206);
      tick(0, 0, 0, 0, 0, 0, 606, 206, acc);
      tick(0, 0, 0, 0, 0, 0, 606, 206, acc);
      repeat (6) idle(606, 206);
      issue(1, 0, 620, 220);
      repeat (6) idle(near_x(), near_y());

      issue(0, 6, 500, 400);
      repeat (6) idle(near_x(), near_y());

      for (int k = 0; k < 60; k++) begin
         op = (k < 3) ? 0 : int'($urandom_range(0, 3));
         x  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023)) :
              (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 600)));
         y  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023)) :
              (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 600)));
         issue(op, int'($urandom_range(0, 7)), x, y);
         repeat ($urandom_range(0, 6)) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            else idle(near_x(), near_y());
         end
      end

      repeat (6) idle(near_x(), near_y());
      @(negedge clk);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tetromino_render.md
TETROMINO_RENDER -- requirements
Module: tetromino_render

Interface
REQ-001 SHALL have parameter SIZE, default 16, cell edge length in pixels (power of two, 4..64).
REQ-002 SHALL have parameter X_W, default 10, pixel x-coordinate width.
REQ-003 SHALL have parameter Y_W, default 10, pixel y-coordinate width.
REQ-004 SHALL have port clk  in  1  single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port addr_x  in  X_W  pixel x being scanned.
REQ-007 SHALL have port addr_y  in  Y_W  pixel y being scanned.
REQ-008 SHALL have port cmd_valid  in  1  command offered.
REQ-009 SHALL have port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-010 SHALL have port cmd_op  in  2  operation: 00 LOAD, 01 MOVE, 10 ROTATE, 11 CLEAR.
REQ-011 SHALL have port cmd_type  in  3  piece type: 0 I, 1 O, 2 T, 3 S, 4 Z, 5 J, 6 L; 7 is reserved.
REQ-012 SHALL have port cmd_x  in  X_W  new reference x.
REQ-013 SHALL have port cmd_y  in  Y_W  new reference y.
REQ-014 SHALL have port upd_done  out  1  one-cycle pulse when a new shape is committed.
REQ-015 SHALL have port en_inner  out  1  pixel lies in a cell interior.
REQ-016 SHALL have port en_edge  out  1  pixel lies on a cell border.

Function
REQ-017 SHALL hold the piece state: type, rotation (2 bits), ref_x, ref_y, visible.
REQ-018 SHALL hold four committed cell origins, cx[i]/cy[i], each X_W+1 / Y_W+1 bits signed.
REQ-019 SHALL accept a command only on a cycle where cmd_valid && cmd_ready.
REQ-020 LOAD SHALL set type, x, y and visible=1, and SHALL clear rotation to 0.
REQ-021 MOVE SHALL update x and y only.
REQ-022 ROTATE SHALL set rotation to (rotation+1) mod 4, wrapping 3 to 0.
REQ-023 LOAD with cmd_type 7 SHALL be treated as type 3 (S).
REQ-024 CLEAR SHALL set visible=0 on the following edge, SHALL keep ready high, and SHALL not pulse upd_done.
REQ-025 FSM states SHALL be IDLE and BUSY; reset state is IDLE.
REQ-026 IDLE SHALL transition to BUSY on acceptance of LOAD, MOVE or ROTATE.
REQ-027 BUSY SHALL last exactly 4 cycles, computing shadow cell idx 0..3, one cell per cycle.
REQ-028 On the 4th BUSY cycle edge, the block SHALL copy all shadow cells to committed, pulse upd_done, and return to IDLE.
REQ-029 cmd_ready SHALL be 1 in IDLE and 0 in BUSY.
REQ-030 Commands offered during BUSY SHALL be held off, not dropped.
REQ-031 Shadow cell i SHALL be cx = ref_x + dx*SIZE and cy = ref_y + dy*SIZE, with dx, dy 3-bit signed in -1..2 taken from the shape table.
REQ-032 Arithmetic SHALL be sign-extended with no wrap; a negative or overflowing cell never matches.
REQ-033 Rendering SHALL use committed cells only, so the display never shows a half-updated piece.
REQ-034 Pixel (ax, ay) SHALL hit cell i when cx <= ax <= cx+SIZE-1 and cy <= ay <= cy+SIZE-1.
REQ-035 A hit pixel SHALL be edge when its local x or y is 0 or SIZE-1, and inner otherwise.
REQ-036 en_edge SHALL be the OR of edge hits and en_inner the OR of inner hits, both gated by visible.
REQ-037 Where overlapping cells give both an edge and an inner hit on one pixel, both outputs SHALL assert.
REQ-038 en_inner and en_edge SHALL be registered, with 1-cycle latency from addr_x/addr_y.
REQ-039 S rotation 0 offsets SHALL be (0,0), (1,0), (0,1), (-1,1).
REQ-040 Offsets for the other types and rotations SHALL be fixed in the package table.

Reset
REQ-041 While rst_n is low, the block SHALL force IDLE, visible=0, type=0, rotation=0, and ref and all cells to 0.
REQ-042 While rst_n is low, outputs SHALL be en_inner=0, en_edge=0 and upd_done=0.
REQ-043 cmd_ready SHALL be 0 while rst_n is low and 1 from the first edge after release.
REQ-044 Reset asserted mid-BUSY SHALL abort the update; no commit occurs and no upd_done pulse is produced.

Structure
REQ-045 A shared package SHALL hold the piece-type and op-code encodings, the FSM state type, and the 7x4x4 offset table.
REQ-046 The package SHALL hold the default SIZE constant.
REQ-047 One sub-module, tetromino_shape_rom, SHALL be combinational: (type, rot, idx) to (dx, dy).
REQ-048 The top SHALL instantiate tetromino_shape_rom once.

Verification
REQ-049 LOAD S at (64,64), then scan (64,64), (70,70), (48,80) and (100,64) SHALL give edge / inner / edge / none on the next cycle; upd_done SHALL fire 5 cycles after acceptance.
REQ-050 Four ROTATEs issued back-to-back on an S SHALL stall on cmd_ready 4 cycles each and SHALL return to the rotation-0 footprint (wrap 3 to 0).
REQ-051 MOVE to (8,8) with dx=-1 SHALL place a cell at x=-8; scans of x=0..7 on that row SHALL hit, and the negative part SHALL never alias to x=1016.
REQ-052 Scanning the old footprint mid-BUSY after a MOVE SHALL give old-position hits until the commit edge and new-position hits only after it.
REQ-053 CLEAR followed by scanning the committed footprint SHALL give en_inner=en_edge=0, with cmd_ready remaining 1.
REQ-054 rst_n driven low on BUSY cycle 2 SHALL produce no upd_done, outputs 0, and visible=0 after release.
